// File: rtl/param_shift_register.sv
// Parametrised shift engine: parallel load, bidirectional shift or rotate,
// plus a shift counter that pulses FRAME once per WIDTH-bit word.
module param_shift_register #(
   parameter int          WIDTH       = 8,
   parameter logic [31:0] RESET_VALUE = 32'h0,
   parameter int          CNT_W       = 4
) (
   input  logic             C,
   input  logic             R,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] D,
   input  logic             EN,
   input  logic             DIR,
   input  logic             ROT,
   input  logic             SI,
   output logic             SO,
   output logic [WIDTH-1:0] Q,
   output logic [CNT_W-1:0] CNT,
   output logic             FRAME
);

   localparam logic [WIDTH-1:0] RST_Q    = RESET_VALUE[WIDTH-1:0];
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic ins_bit;

   // Concatenate the inserted bit onto the word and keep the low WIDTH bits;
   // this form also covers WIDTH=1 without an empty slice.
   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] q,
                                                   input logic             dir,
                                                   input logic             b);
      if (dir)
         return WIDTH'({b, q} >> 1);
      else
         return WIDTH'({q, b});
   endfunction

   assign SO      = DIR ? Q[0] : Q[WIDTH-1];
   assign ins_bit = ROT ? SO : SI;

   always_ff @(posedge C) begin
      if (R) begin
         Q     <= RST_Q;
         CNT   <= '0;
         FRAME <= 1'b0;
      end else if (LOAD) begin
         Q     <= D;
         CNT   <= '0;
         FRAME <= 1'b0;
      end else if (EN) begin
         Q <= shift_word(Q, DIR, ins_bit);
         if (CNT == CNT_LAST) begin
            CNT   <= '0;
            FRAME <= 1'b1;
         end else begin
            CNT   <= CNT + 1'b1;
            FRAME <= 1'b0;
         end
      end else begin
         FRAME <= 1'b0;
      end
   end

endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register: four instances (8-bit A5 reset, 8-bit zero
// reset, 1-bit, 16-bit) share one stimulus stream and are checked against a model.
module tb_param_shift_register;

   logic        C = 1'b0;
   logic        R = 1'b0, LOAD = 1'b0, EN = 1'b0, DIR = 1'b0, ROT = 1'b0, SI = 1'b0;
   logic [31:0] dd = '0;

   logic [7:0]  q0, q1;
   logic [0:0]  q2;
   logic [15:0] q3;
   logic [3:0]  c0, c1, c2, c3;
   logic        f0, f1, f2, f3, s0, s1, s2, s3;

   logic [31:0] aq[4], ac[4], af[4], as[4];

   logic [31:0] mq[4];
   int          mcnt[4];
   logic        mfr[4];
   int          mw[4]  = '{8, 8, 1, 16};
   logic [31:0] mrv[4] = '{32'hA5, 32'h0, 32'h0, 32'h1234};

   int nvec = 0;
   int nerr = 0;

   always #5 C = ~C;

   param_shift_register #(.WIDTH(8), .RESET_VALUE(32'hA5), .CNT_W(4)) u0 (
      .C(C), .R(R), .LOAD(LOAD), .D(dd[7:0]), .EN(EN), .DIR(DIR), .ROT(ROT), .SI(SI),
      .SO(s0), .Q(q0), .CNT(c0), .FRAME(f0));
   param_shift_register #(.WIDTH(8), .RESET_VALUE(32'h0), .CNT_W(4)) u1 (
      .C(C), .R(R), .LOAD(LOAD), .D(dd[7:0]), .EN(EN), .DIR(DIR), .ROT(ROT), .SI(SI),
      .SO(s1), .Q(q1), .CNT(c1), .FRAME(f1));
   param_shift_register #(.WIDTH(1), .RESET_VALUE(32'h0), .CNT_W(4)) u2 (
      .C(C), .R(R), .LOAD(LOAD), .D(dd[0:0]), .EN(EN), .DIR(DIR), .ROT(ROT), .SI(SI),
      .SO(s2), .Q(q2), .CNT(c2), .FRAME(f2));
   param_shift_register #(.WIDTH(16), .RESET_VALUE(32'h1234), .CNT_W(4)) u3 (
      .C(C), .R(R), .LOAD(LOAD), .D(dd[15:0]), .EN(EN), .DIR(DIR), .ROT(ROT), .SI(SI),
      .SO(s3), .Q(q3), .CNT(c3), .FRAME(f3));

   assign aq[0] = 32'(q0);  assign aq[1] = 32'(q1);  assign aq[2] = 32'(q2);  assign aq[3] = 32'(q3);
   assign ac[0] = 32'(c0);  assign ac[1] = 32'(c1);  assign ac[2] = 32'(c2);  assign ac[3] = 32'(c3);
   assign af[0] = 32'(f0);  assign af[1] = 32'(f1);  assign af[2] = 32'(f2);  assign af[3] = 32'(f3);
   assign as[0] = 32'(s0);  assign as[1] = 32'(s1);  assign as[2] = 32'(s2);  assign as[3] = 32'(s3);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mask_of(input int w);
      return (32'd1 << w) - 32'd1;
   endfunction

   function automatic logic [31:0] model_so(input int k);
      return DIR ? (mq[k] & 32'd1) : ((mq[k] >> (mw[k] - 1)) & 32'd1);
   endfunction

   // Model advances from the spec's priority rules using plain arithmetic.
   task automatic model_edge();
      for (int k = 0; k < 4; k++) begin
         logic [31:0] b;
         if (R) begin
            mq[k] = mrv[k] & mask_of(mw[k]);  mcnt[k] = 0;  mfr[k] = 1'b0;
         end else if (LOAD) begin
            mq[k] = dd & mask_of(mw[k]);      mcnt[k] = 0;  mfr[k] = 1'b0;
         end else if (EN) begin
            b = ROT ? model_so(k) : 32'(SI);
            if (DIR) mq[k] = (mq[k] >> 1) | (b << (mw[k] - 1));
            else     mq[k] = ((mq[k] << 1) | b) & mask_of(mw[k]);
            if (mcnt[k] == mw[k] - 1) begin mcnt[k] = 0; mfr[k] = 1'b1; end
            else begin mcnt[k] = mcnt[k] + 1; mfr[k] = 1'b0; end
         end else begin
            mfr[k] = 1'b0;
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("q%0d", k),     aq[k], mq[k]);
         chk($sformatf("cnt%0d", k),   ac[k], 32'(mcnt[k]));
         chk($sformatf("frame%0d", k), af[k], 32'(mfr[k]));
         chk($sformatf("so%0d", k),    as[k], model_so(k));
      end
   endtask

   task automatic tick();
      @(posedge C);
      model_edge();
      #1;
      check_all();
   endtask

   logic [7:0] sipo_bits = 8'b1011_0010;
   logic [7:0] piso_exp  = 8'b1000_0001;

   initial begin
      foreach (mq[k]) begin mq[k] = '0; mcnt[k] = 0; mfr[k] = 1'b0; end

      // Reset held for two cycles
      R = 1'b1;
      tick();
      tick();
      chk("rst_q0", aq[0], 32'hA5);
      chk("rst_so0", as[0], 32'h1);
      chk("rst_cnt0", ac[0], 32'h0);
      chk("rst_frame0", af[0], 32'h0);

      // SIPO, MSB-first arrival
      R = 1'b0; EN = 1'b1; DIR = 1'b0; ROT = 1'b0;
      for (int i = 0; i < 8; i++) begin
         SI = sipo_bits[7-i];
         tick();
         chk("w1_frame_every_shift", af[2], 32'h1);
         if (i < 7) chk("sipo_frame_early", af[1], 32'h0);
      end
      chk("sipo_q", aq[1], 32'hB2);
      chk("sipo_frame", af[1], 32'h1);
      chk("sipo_cnt", ac[1], 32'h0);
      SI = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i < 7) chk("sipo2_frame_early", af[1], 32'h0);
         if (i < 7) chk("w16_frame_early", af[3], 32'h0);
      end
      chk("sipo2_frame", af[1], 32'h1);
      chk("w16_frame", af[3], 32'h1);

      // PISO toward LSB
      EN = 1'b0; LOAD = 1'b1; dd = 32'h81;
      tick();
      LOAD = 1'b0; DIR = 1'b1; EN = 1'b1; SI = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("piso_so%0d", i), as[1], 32'(piso_exp[7-i]));
         tick();
      end
      chk("piso_q", aq[1], 32'h0);
      chk("piso_frame", af[1], 32'h1);

      // Rotate toward MSB, SI toggling must not matter
      EN = 1'b0; LOAD = 1'b1; dd = 32'h01;
      tick();
      LOAD = 1'b0; DIR = 1'b0; ROT = 1'b1; EN = 1'b1;
      for (int i = 0; i < 8; i++) begin
         SI = ~SI;
         tick();
         chk($sformatf("rot_q%0d", i), aq[1], 32'h1 << ((i + 1) % 8));
      end
      chk("rot_frame", af[1], 32'h1);

      // LOAD beats EN at CNT=5, then R beats LOAD
      ROT = 1'b0; SI = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("pre_load_cnt", ac[1], 32'h5);
      LOAD = 1'b1; dd = 32'h3C;
      tick();
      chk("load_q", aq[1], 32'h3C);
      chk("load_cnt", ac[1], 32'h0);
      chk("load_frame", af[1], 32'h0);
      R = 1'b1;
      tick();
      chk("rst_over_load_q0", aq[0], 32'hA5);
      chk("rst_over_load_q1", aq[1], 32'h0);

      // Mid-frame hold then reset discards the partial frame
      R = 1'b0; LOAD = 1'b0; EN = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      EN = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("hold_cnt", ac[1], 32'h3);
         chk("hold_frame", af[1], 32'h0);
      end
      R = 1'b1;
      tick();
      chk("midrst_cnt", ac[1], 32'h0);
      R = 1'b0; EN = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("post_rst_frame", af[1], (i == 7) ? 32'h1 : 32'h0);
      end

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         R    = ($urandom_range(0, 31) == 0);
         LOAD = ($urandom_range(0, 7) == 0);
         EN   = ($urandom_range(0, 3) != 0);
         DIR  = ($urandom_range(0, 3) == 0) ? ~DIR : DIR;
         ROT  = ($urandom_range(0, 5) == 0) ? ~ROT : ROT;
         SI   = 1'($urandom);
         dd   = $urandom;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
